// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding,
// parity-mode selectors and the smallest usable baud divisor.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    // Below this the half-bit START delay collapses to nothing useful.
    localparam int MIN_DIV = 4;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous receive line; resets to the
// idle-high level so a line held low through reset is not seen for 2 cycles.
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic i_rx,
    output logic o_rx
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = i_rx;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign o_rx = sync_q;

endmodule

// File: rtl/uart_rx_framer.sv
// UART receiver: oversampling-free mid-bit sampler with configurable width,
// parity and stop bits, plus a one-word holding register with overrun flag.
module uart_rx_framer
    import uart_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int DIV_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_rx,
    input  logic              i_start_rx,
    input  logic [DIV_W-1:0]  i_div,
    input  logic              i_data_ready,
    input  logic              i_clr_ovr,
    output logic [DATA_W-1:0] o_data,
    output logic              o_data_valid,
    output logic              o_parity_err,
    output logic              o_frame_err,
    output logic              o_overrun,
    output logic              o_busy
);

    localparam int                BIT_W     = $clog2(DATA_W + 1);
    localparam logic [DIV_W-1:0]  MIN_DIV_V = DIV_W'(MIN_DIV);
    localparam logic [BIT_W-1:0]  LAST_DATA = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0]  LAST_STOP = BIT_W'(STOP_BITS - 1);

    logic              rx_s;
    uart_state_e       state_q, state_d;
    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              par_err_q, par_err_d;
    logic              frm_err_q, frm_err_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              perr_q, perr_d;
    logic              ferr_q, ferr_d;
    logic              ovr_q, ovr_d;
    logic              expire;
    logic              complete;
    logic              exp_par;
    logic [DIV_W-1:0]  div_clamped;

    uart_rx_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_rx  (i_rx),
        .o_rx  (rx_s)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        div_d       = div_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        par_err_d   = par_err_q;
        frm_err_d   = frm_err_q;
        complete    = 1'b0;
        expire      = (cnt_q <= DIV_W'(1));
        div_clamped = (i_div < MIN_DIV_V) ? MIN_DIV_V : i_div;
        exp_par     = (PARITY == PARITY_ODD) ? ~^shift_q : ^shift_q;

        if (state_q != ST_IDLE) begin
            cnt_d = cnt_q - DIV_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                // Divisor is latched here so i_div changes cannot disturb a frame.
                if (!rx_s && i_start_rx) begin
                    state_d   = ST_START;
                    div_d     = div_clamped;
                    cnt_d     = div_clamped >> 1;
                    bit_d     = '0;
                    par_err_d = 1'b0;
                    frm_err_d = 1'b0;
                end
            end
            ST_START: begin
                if (expire) begin
                    if (!rx_s) begin
                        state_d = ST_DATA;
                        cnt_d   = div_q;
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end
            end
            ST_DATA: begin
                if (expire) begin
                    shift_d = {rx_s, shift_q[DATA_W-1:1]};
                    cnt_d   = div_q;
                    if (bit_q == LAST_DATA) begin
                        bit_d   = '0;
                        state_d = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (expire) begin
                    par_err_d = (rx_s != exp_par);
                    state_d   = ST_STOP;
                    cnt_d     = div_q;
                end
            end
            ST_STOP: begin
                if (expire) begin
                    if (!rx_s) begin
                        frm_err_d = 1'b1;
                    end
                    if (bit_q == LAST_STOP) begin
                        state_d  = ST_IDLE;
                        complete = 1'b1;
                        cnt_d    = '0;
                        bit_d    = '0;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                        cnt_d = div_q;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Holding register: a completing word only lands if the slot is free or
    // being consumed this same cycle; otherwise it is dropped and flagged.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        ovr_d   = ovr_q;

        if (valid_q && i_data_ready) begin
            valid_d = 1'b0;
        end
        if (i_clr_ovr) begin
            ovr_d = 1'b0;
        end
        if (complete) begin
            if (!valid_q || i_data_ready) begin
                data_d  = shift_q;
                perr_d  = par_err_q;
                ferr_d  = frm_err_d;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            div_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            par_err_q <= 1'b0;
            frm_err_q <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            par_err_q <= par_err_d;
            frm_err_q <= frm_err_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
        end
    end

    assign o_data       = data_q;
    assign o_data_valid = valid_q;
    assign o_parity_err = perr_q;
    assign o_frame_err  = ferr_q;
    assign o_overrun    = ovr_q;
    assign o_busy       = (state_q != ST_IDLE);

endmodule
